// File: rtl/alu_seq_ctrl_if.sv
// ============================================================================
// Module      : alu_seq_ctrl_if
// Description : Bundle between the ALU sequencer and its surroundings:
//               start request, instruction-memory port, ALU / register-file
//               control and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_seq_ctrl_if #(
   parameter int ADDR_W = 15,
   parameter int XLEN   = 64
);
   logic              start;
   logic [ADDR_W-1:0] start_pc;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic [4:0]        rd;
   logic              alu_src_imm;
   logic [XLEN-1:0]   imm;
   logic              rf_we;
   logic [ADDR_W-1:0] pc;
   logic              busy;
   logic              done;
   logic              err;

   // Environment side: issues start, returns memory data, consumes control.
   modport master (
      output start, start_pc, imem_rdata,
      input  imem_addr, funct3, funct7, rs1, rs2, rd, alu_src_imm, imm,
             rf_we, pc, busy, done, err
   );

   // Sequencer side.
   modport slave (
      input  start, start_pc, imem_rdata,
      output imem_addr, funct3, funct7, rs1, rs2, rd, alu_src_imm, imm,
             rf_we, pc, busy, done, err
   );
endinterface

`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
// ============================================================================
// Module      : alu_seq_ctrl
// Description : Multi-cycle fetch/decode sequencer for RV64 OP and OP-IMM
//               instructions. Drives the instruction memory address, the ALU
//               control fields and a one-cycle register-file write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_ctrl #(
   parameter int ADDR_W = 15,
   parameter int XLEN   = 64
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   alu_seq_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_MEM    = 3'd2,
      S_DECODE = 3'd3,
      S_EXEC   = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [6:0]  c_OPC_OP    = 7'b0110011;
   localparam logic [6:0]  c_OPC_OPIMM = 7'b0010011;
   localparam logic [31:0] c_ECALL     = 32'h0000_0073;

   state_t            r_state;
   logic [31:0]       r_ir;
   logic [ADDR_W-1:0] r_pc;
   logic [2:0]        r_funct3;
   logic [6:0]        r_funct7;
   logic [4:0]        r_rs1;
   logic [4:0]        r_rs2;
   logic [4:0]        r_rd;
   logic              r_alu_src_imm;
   logic [XLEN-1:0]   r_imm;
   logic              r_rf_we;
   logic              r_busy;
   logic              r_done;
   logic              r_err;

   logic [6:0]        w_mem_opc;
   logic [2:0]        w_mem_f3;
   logic              w_mem_shift;
   logic [XLEN-1:0]   w_mem_imm;
   logic [6:0]        w_ir_opc;
   logic [ADDR_W-1:0] w_pc_next;

   // Pre-decode of the word arriving from memory so that the field outputs
   // are already valid during DECODE, in the same cycle ir becomes valid.
   assign w_mem_opc   = bus.imem_rdata[6:0];
   assign w_mem_f3    = bus.imem_rdata[14:12];
   assign w_mem_shift = (w_mem_f3 == 3'b001) || (w_mem_f3 == 3'b101);
   assign w_mem_imm   = {{(XLEN-12){bus.imem_rdata[31]}}, bus.imem_rdata[31:20]};
   assign w_ir_opc    = r_ir[6:0];
   // Natural wrap at 2^ADDR_W.
   assign w_pc_next   = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_ir          <= '0;
         r_pc          <= '0;
         r_funct3      <= '0;
         r_funct7      <= '0;
         r_rs1         <= '0;
         r_rs2         <= '0;
         r_rd          <= '0;
         r_alu_src_imm <= 1'b0;
         r_imm         <= '0;
         r_rf_we       <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_HALT: begin
               // start is only honoured while not busy; no queueing.
               if (bus.start) begin
                  r_pc    <= bus.start_pc;
                  r_err   <= 1'b0;
                  r_done  <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_FETCH;
               end
            end
            S_FETCH: begin
               r_state <= S_MEM;
            end
            S_MEM: begin
               r_ir     <= bus.imem_rdata;
               r_funct3 <= w_mem_f3;
               r_rs1    <= bus.imem_rdata[19:15];
               r_rs2    <= bus.imem_rdata[24:20];
               r_rd     <= bus.imem_rdata[11:7];
               if (w_mem_opc == c_OPC_OP) begin
                  r_funct7      <= bus.imem_rdata[31:25];
                  r_alu_src_imm <= 1'b0;
               end else if (w_mem_opc == c_OPC_OPIMM) begin
                  // Only shifts carry a meaningful funct7 in OP-IMM.
                  r_funct7      <= w_mem_shift ? bus.imem_rdata[31:25] : 7'd0;
                  r_alu_src_imm <= 1'b1;
                  r_imm         <= w_mem_imm;
               end
               r_state <= S_DECODE;
            end
            S_DECODE: begin
               if (r_ir == c_ECALL) begin
                  r_done  <= 1'b1;
                  r_err   <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= S_HALT;
               end else if ((w_ir_opc == c_OPC_OP) || (w_ir_opc == c_OPC_OPIMM)) begin
                  r_state <= S_EXEC;
               end else begin
                  r_done  <= 1'b1;
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_HALT;
               end
            end
            S_EXEC: begin
               // Writes to x0 are suppressed at the strobe.
               r_rf_we <= (r_rd != 5'd0);
               r_state <= S_WB;
            end
            S_WB: begin
               r_rf_we <= 1'b0;
               r_pc    <= w_pc_next;
               r_state <= S_FETCH;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.imem_addr   = r_pc;
   assign bus.pc          = r_pc;
   assign bus.funct3      = r_funct3;
   assign bus.funct7      = r_funct7;
   assign bus.rs1         = r_rs1;
   assign bus.rs2         = r_rs2;
   assign bus.rd          = r_rd;
   assign bus.alu_src_imm = r_alu_src_imm;
   assign bus.imm         = r_imm;
   assign bus.rf_we       = r_rf_we;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
// ============================================================================
// Module      : tb_alu_seq_ctrl
// Description : Directed self-checking bench for alu_seq_ctrl with a
//               synchronous instruction-memory model and a write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq_ctrl;

   logic clk;
   logic rst_n;

   alu_seq_ctrl_if #(.ADDR_W(15), .XLEN(64)) bus ();

   alu_seq_ctrl #(.ADDR_W(15), .XLEN(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [31:0] mem [0:32767];

   typedef struct {
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        src;
      logic        chk_imm;
      logic [63:0] imm;
      logic [14:0] pc;
      int          cyc;
   } wr_t;

   wr_t sb[$];
   int  vectors     = 0;
   int  miscompares = 0;

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read instruction memory.
   always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_wr(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [2:0] f3, input logic [6:0] f7, input logic src,
                          input logic chk_imm, input logic [63:0] imm,
                          input logic [14:0] pc, input int cyc);
      wr_t e;
      e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.f3 = f3; e.f7 = f7; e.src = src;
      e.chk_imm = chk_imm; e.imm = imm; e.pc = pc; e.cyc = cyc;
      sb.push_back(e);
   endtask

   // Called at a sample point; returns at the sample point of cycle 1.
   task automatic pulse_start(input logic [14:0] spc);
      bus.start    = 1'b1;
      bus.start_pc = spc;
      @(posedge clk); #1;
      bus.start    = 1'b0;
      chk("busy_rise", {63'd0, bus.busy}, 64'd1);
      chk("done_clr",  {63'd0, bus.done}, 64'd0);
      chk("err_clr",   {63'd0, bus.err},  64'd0);
      chk("pc_load",   {49'd0, bus.pc},   {49'd0, spc});
   endtask

   // Steps cycles from cycle 1, scoring write strobes until HALT.
   task automatic run_prog(input int halt_cyc, input logic exp_err,
                           input logic [14:0] exp_pc, input int ign_cyc);
      logic halted;
      wr_t  e;
      halted = 1'b0;
      for (int c = 1; c <= 60 && !halted; c++) begin
         if (c > 1) begin
            @(posedge clk); #1;
         end
         bus.start = 1'b0;
         if (c == ign_cyc) begin
            bus.start    = 1'b1;
            bus.start_pc = 15'h0100;
         end
         if (bus.rf_we) begin
            if (sb.size() == 0) begin
               chk("we_unexpected", {63'd0, bus.rf_we}, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("we_cycle",  64'(c), 64'(e.cyc));
               chk("we_rd",     {59'd0, bus.rd},  {59'd0, e.rd});
               chk("we_rs1",    {59'd0, bus.rs1}, {59'd0, e.rs1});
               chk("we_rs2",    {59'd0, bus.rs2}, {59'd0, e.rs2});
               chk("we_funct3", {61'd0, bus.funct3}, {61'd0, e.f3});
               chk("we_funct7", {57'd0, bus.funct7}, {57'd0, e.f7});
               chk("we_src",    {63'd0, bus.alu_src_imm}, {63'd0, e.src});
               chk("we_pc",     {49'd0, bus.pc}, {49'd0, e.pc});
               if (e.chk_imm) chk("we_imm", bus.imm, e.imm);
            end
         end
         if (bus.done) begin
            halted = 1'b1;
            chk("halt_cycle", 64'(c), 64'(halt_cyc));
            chk("halt_err",   {63'd0, bus.err},  {63'd0, exp_err});
            chk("halt_pc",    {49'd0, bus.pc},   {49'd0, exp_pc});
            chk("halt_addr",  {49'd0, bus.imem_addr}, {49'd0, exp_pc});
            chk("halt_busy",  {63'd0, bus.busy}, 64'd0);
            chk("sb_left",    64'(sb.size()), 64'd0);
         end
      end
      bus.start = 1'b0;
      if (!halted) chk("halt_timeout", {63'd0, bus.done}, 64'd1);
      sb.delete();
   endtask

   // Directed test sequence.
   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = 32'hFFFF_FFFF;
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.start_pc = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pc",    {49'd0, bus.pc}, 64'd0);
      chk("rst_addr",  {49'd0, bus.imem_addr}, 64'd0);
      chk("rst_ctl",   {39'd0, bus.funct3, bus.funct7, bus.rs1, bus.rs2, bus.rd, bus.alu_src_imm}, 64'd0);
      chk("rst_imm",   bus.imm, 64'd0);
      chk("rst_flags", {60'd0, bus.rf_we, bus.busy, bus.done, bus.err}, 64'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_busy", {63'd0, bus.busy}, 64'd0);

      // ADD then ECALL.
      mem[0] = 32'h0020_81B3;
      mem[1] = 32'h0000_0073;
      push_wr(5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 1'b0, 1'b0, 64'd0, 15'd0, 5);
      pulse_start(15'd0);
      run_prog(9, 1'b0, 15'd1, 0);

      // OP-IMM mix, rd=0 write, with a start pulse while busy.
      mem[10] = 32'hFFF0_0093;   // addi x1,x0,-1
      mem[11] = 32'h4030_D093;   // srai x1,x1,3
      mem[12] = 32'h7FF3_6293;   // ori  x5,x6,0x7ff
      mem[13] = 32'h0000_0033;   // add  x0,x0,x0
      mem[14] = 32'h0000_0073;
      push_wr(5'd1, 5'd0, 5'd31, 3'd0, 7'h00, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 15'd10, 5);
      push_wr(5'd1, 5'd1, 5'd3,  3'd5, 7'h20, 1'b1, 1'b1, 64'h403, 15'd11, 10);
      push_wr(5'd5, 5'd6, 5'd31, 3'd6, 7'h00, 1'b1, 1'b1, 64'h7FF, 15'd12, 15);
      pulse_start(15'd10);
      run_prog(24, 1'b0, 15'd14, 7);

      // Illegal instruction at address 5.
      mem[3] = 32'h0020_81B3;
      mem[4] = 32'hFFF0_0093;
      push_wr(5'd3, 5'd1, 5'd2,  3'd0, 7'd0, 1'b0, 1'b0, 64'd0, 15'd3, 5);
      push_wr(5'd1, 5'd0, 5'd31, 3'd0, 7'd0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 15'd4, 10);
      pulse_start(15'd3);
      run_prog(14, 1'b1, 15'd5, 0);

      // Restart from HALT clears err.
      push_wr(5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 1'b0, 1'b0, 64'd0, 15'd0, 5);
      pulse_start(15'd0);
      run_prog(9, 1'b0, 15'd1, 0);

      // PC wrap from 0x7FFF to 0.
      mem[15'h7FFF] = 32'h0020_81B3;
      mem[0]        = 32'h0000_0073;
      push_wr(5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 1'b0, 1'b0, 64'd0, 15'h7FFF, 5);
      pulse_start(15'h7FFF);
      run_prog(9, 1'b0, 15'd0, 0);

      // Reset asserted during WB.
      mem[0] = 32'h0020_81B3;
      mem[1] = 32'h0000_0073;
      pulse_start(15'd0);
      for (int c = 2; c <= 5; c++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         if (c == 2) begin
            bus.start    = 1'b1;
            bus.start_pc = 15'h0055;
         end
      end
      chk("wb_we",  {63'd0, bus.rf_we}, 64'd1);
      chk("wb_pc",  {49'd0, bus.pc}, 64'd0);
      chk("wb_rd",  {59'd0, bus.rd}, 64'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("rstwb_we",    {63'd0, bus.rf_we}, 64'd0);
      chk("rstwb_pc",    {34'd0, bus.pc, bus.imem_addr}, 64'd0);
      chk("rstwb_ctl",   {39'd0, bus.funct3, bus.funct7, bus.rs1, bus.rs2, bus.rd, bus.alu_src_imm}, 64'd0);
      chk("rstwb_imm",   bus.imm, 64'd0);
      chk("rstwb_flags", {61'd0, bus.busy, bus.done, bus.err}, 64'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_busy", {63'd0, bus.busy}, 64'd0);
      chk("post_rst_we",   {63'd0, bus.rf_we}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle sequencer that drives the core's instruction memory and 64-bit ALU. From a latched start PC it fetches 32-bit instructions from the synchronous instruction memory and decodes RV64 OP/OP-IMM formats. For each instruction it presents ALU control (funct3/funct7, operand select, immediate) and issues one register-file write. It sits between `instr_mem_gen` and `alu` inside `core` and replaces the fixed `funct3=0`/`funct7=0` tie-off.

## Interface
- Parameters:
- `ADDR_W`, 15: instruction memory word-address width.
- `XLEN`, 64: ALU/immediate width.
- Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; honoured only in IDLE or HALT.
- `start_pc` in ADDR_W: word address latched on an honoured `start`.
- `imem_addr` out ADDR_W: address to `instr_mem_gen.addra`.
- `imem_rdata` in 32: `instr_mem_gen.douta`; valid one cycle after the address is sampled.
- `funct3` out 3, `funct7` out 7: ALU control.
- `rs1`, `rs2`, `rd` out 5: register-file indices.
- `alu_src_imm` out 1: 1 selects `imm` as ALU `in2`.
- `imm` out XLEN: sign-extended I-immediate.
- `rf_we` out 1: register-file write strobe (one cycle).
- `pc` out ADDR_W: current instruction word address.
- `busy` out 1: high in every state except IDLE and HALT.
- `done` out 1: high while in HALT.
- `err` out 1: high while in HALT if the halt cause was an illegal instruction.

## Operation
- States:
  - IDLE, then FETCH, MEM, DECODE, EXEC, WB, and back to FETCH.
  - From DECODE, an ECALL or illegal instruction goes to HALT.
- IDLE or HALT with `start=1`:
  - `pc <= start_pc`, clear `err`, go to FETCH.
- FETCH: `imem_addr = pc` (driven combinationally from `pc` in all states).
- MEM: wait for the BRAM read. At the end of MEM, `ir <= imem_rdata`.
- DECODE, with opcode = `ir[6:0]`:
  - `0110011` (OP): `funct7 = ir[31:25]`, `alu_src_imm = 0`.
  - `0010011` (OP-IMM): `alu_src_imm = 1`, `imm = sext(ir[31:20])`.
    - `funct7 = ir[31:25]` when `funct3` is `001` or `101` (shifts).
    - Otherwise `funct7 = 0`.
  - `ir == 32'h00000073` (ECALL): go to HALT, `err = 0`.
  - Any other opcode: go to HALT, `err = 1`, `pc` unchanged.
- Field outputs:
  - `funct3 = ir[14:12]`, `rs1 = ir[19:15]`, `rs2 = ir[24:20]`, `rd = ir[11:7]`.
  - These are registered from `ir` and held stable through DECODE, EXEC and WB.
- EXEC: one cycle for ALU settle; no outputs change.
- WB:
  - `rf_we = 1` for exactly this cycle, except `rd == 0` forces `rf_we = 0`.
  - `pc <= pc + 1` modulo 2^ADDR_W (`0x7FFF` wraps to `0x0000`).
  - Go to FETCH.
- HALT: outputs hold. `done = 1` until a new `start` or reset.
- `start` while `busy` is ignored; no queueing.

## Timing
- Reset (async assert, sync deassert assumed handled upstream) forces:
  - state IDLE; `pc`, `ir`, `imem_addr` = 0.
  - `funct3`, `funct7`, `rs1`, `rs2`, `rd`, `imm` = 0; `alu_src_imm` = 0.
  - `rf_we`, `busy`, `done`, `err` = 0.
- Reset mid-instruction, including in WB, drops `rf_we` immediately. No partial write is retried.
- Throughput: 5 cycles per executed instruction (FETCH through WB).
- Latency from an honoured `start` (cycle 0):
  - FETCH at cycle 1; `ir` valid at cycle 3.
  - First `rf_we` at cycle 5; next FETCH at cycle 6.
- ECALL/illegal: DECODE at cycle 3, HALT with `done=1` at cycle 4. No `rf_we` for that instruction.
- `start` asserted in HALT: `done` and `err` drop the next cycle, with the FETCH entry.
- `busy` rises the cycle after an honoured `start` and falls on HALT entry.

## Test plan
- ADD sequence: reset, memory `[0]=0x002081B3` (add x3,x1,x2), `[1]=0x00000073`, `start` with `start_pc=0`.
  - Expect `rf_we` at cycle 5 with `rd=3`, `rs1=1`, `rs2=2`, `funct3=0`, `funct7=0`, `alu_src_imm=0`.
  - Expect `done=1`, `err=0` at cycle 9, and `pc=1`.
- OP-IMM: `0xFFF00093` (addi x1,x0,-1).
  - Expect `imm=0xFFFF_FFFF_FFFF_FFFF`, `alu_src_imm=1`, `funct7=0`.
  - SRAI `0x4030D093` gives `funct3=101`, `funct7=0x20`.
- `rd=0` (`0x00000033`): no `rf_we` pulse; `pc` still advances.
- Illegal `0xFFFFFFFF` at address 5: HALT with `err=1`, `pc=5`. A subsequent `start` with `start_pc=0` clears `err`.
- Wrap: `start_pc=0x7FFF` holding an ADD, `[0]` = ECALL. Expect `pc` 0x7FFF then 0x0000, then halt.
- Assert `rst_n=0` during WB: `rf_we` drops in the same cycle, all outputs are 0, and `start` mid-run is ignored.
